// File: rtl/apb_master.sv
// Free-running APB requester: mirrors the local request port onto back-to-back APB transfers.
// Optional ACCESS wait-state timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PWRITE_MASTER,
  input  logic [ADDR_W-1:0] PADDR_MASTER,
  input  logic [DATA_W-1:0] PWDATA_MASTER,
  output logic [DATA_W-1:0] PRDATA_MASTER,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state = IDLE;
  state_t state_next;

  logic              psel_next;
  logic              penable_next;
  logic              pwrite_next;
  logic [ADDR_W-1:0] paddr_next;
  logic [DATA_W-1:0] pwdata_next;
  logic [DATA_W-1:0] prdata_next;
  logic              capture;
  logic              abort;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // abort fires on the edge that ends the TIMEOUT_CYCLES-th PREADY-low ACCESS cycle
  assign abort = (state == ACCESS) && !PREADY &&
                 (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET || state != ACCESS)
      wait_cnt <= '0;
    else if (!PREADY)
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    psel_next    = PSEL;
    penable_next = PENABLE;
    pwrite_next  = PWRITE;
    paddr_next   = PADDR;
    pwdata_next  = PWDATA;
    prdata_next  = PRDATA_MASTER;
    capture      = 1'b0;

    case (state)
      IDLE: begin
        state_next = SETUP;
        capture    = 1'b1;
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (PREADY || abort) begin
          state_next = SETUP;
          capture    = 1'b1;
          if (!PWRITE)
            prdata_next = abort ? DATA_W'(32'hDEAD_BEEF) : PRDATA;
        end
      end
      default: state_next = IDLE;
    endcase

    // every entry into SETUP re-samples the local request port
    if (capture) begin
      psel_next    = 1'b1;
      penable_next = 1'b0;
      pwrite_next  = PWRITE_MASTER;
      paddr_next   = PADDR_MASTER;
      pwdata_next  = PWDATA_MASTER;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      PSEL          <= 1'b0;
      PENABLE       <= 1'b0;
      PWRITE        <= 1'b0;
      PADDR         <= '0;
      PWDATA        <= '0;
      PRDATA_MASTER <= '0;
    end else begin
      state         <= state_next;
      PSEL          <= psel_next;
      PENABLE       <= penable_next;
      PWRITE        <= pwrite_next;
      PADDR         <= paddr_next;
      PWDATA        <= pwdata_next;
      PRDATA_MASTER <= prdata_next;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: register-file slave plus a transfer-level reference model.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PWRITE_MASTER;
  logic [31:0] PADDR_MASTER;
  logic [31:0] PWDATA_MASTER;
  logic [31:0] PRDATA_MASTER;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  logic [31:0] slave_mem [4];
  logic [31:0] junk;

  logic [31:0] exp_mem [4];
  logic [31:0] exp_prdata;
  logic        pend_valid;
  logic        pend_we;
  logic [31:0] pend_addr;
  logic [31:0] pend_data;

  int total = 0;
  int bad   = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PWRITE_MASTER(PWRITE_MASTER), .PADDR_MASTER(PADDR_MASTER),
    .PWDATA_MASTER(PWDATA_MASTER), .PRDATA_MASTER(PRDATA_MASTER),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Slave drives garbage while not ready so early latching is visible
  assign PRDATA = PREADY ? slave_mem[PADDR[3:2]] : junk;

  always @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < 4; i++) slave_mem[i] <= '0;
    end else if (PSEL && PENABLE && PWRITE && PREADY) begin
      slave_mem[PADDR[3:2]] <= PWDATA;
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Retire the outstanding transfer into the reference model
  task automatic complete_pending();
    if (pend_valid) begin
      if (pend_we) exp_mem[pend_addr[3:2]] = pend_data;
      else         exp_prdata = exp_mem[pend_addr[3:2]];
      pend_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_mem[i] = '0;
    exp_prdata = '0;
    pend_valid = 1'b0;
  endtask

  // Starts from IDLE or the last ACCESS cycle of the previous transfer; ends in the
  // final ACCESS cycle of this one (completion happens on the next issue's edge).
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input int waits);
    PWRITE_MASTER = we;
    PADDR_MASTER  = addr;
    PWDATA_MASTER = data;
    PREADY        = 1'b1;
    step();
    complete_pending();
    pend_valid = 1'b1; pend_we = we; pend_addr = addr; pend_data = data;
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, we, addr, data}) begin
      bad++;
      $display("[TB] FAIL setup_bus got=%h exp=%h",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, 1'b0, we, addr, data});
    end
    total++;
    if (PRDATA_MASTER !== exp_prdata) begin
      bad++;
      $display("[TB] FAIL setup_prdata got=%h exp=%h", PRDATA_MASTER, exp_prdata);
    end
    PREADY        = (waits == 0);
    PWRITE_MASTER = 1'($urandom);
    PADDR_MASTER  = $urandom;
    PWDATA_MASTER = $urandom;
    junk          = $urandom;
    step();
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b1, we, addr, data}) begin
      bad++;
      $display("[TB] FAIL access_bus got=%h exp=%h",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, 1'b1, we, addr, data});
    end
    for (int i = 0; i < waits; i++) begin
      PWRITE_MASTER = 1'($urandom);
      PADDR_MASTER  = $urandom;
      PWDATA_MASTER = $urandom;
      junk          = $urandom;
      step();
      total++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA_MASTER} !==
          {1'b1, 1'b1, we, addr, data, exp_prdata}) begin
        bad++;
        $display("[TB] FAIL wait_hold cyc=%0d got=%h exp=%h", i,
                 {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA_MASTER},
                 {1'b1, 1'b1, we, addr, data, exp_prdata});
      end
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1; PREADY = 1'b1; junk = '0;
    PWRITE_MASTER = 1'b1; PADDR_MASTER = 32'hC; PWDATA_MASTER = 32'hFFFF_FFFF;
    step();
    step();
    model_reset();
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA_MASTER} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h exp=0",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA_MASTER});
    end
    PRESET = 1'b0;
  endtask

  task automatic test_writes();
    issue(1'b1, 32'h0, 32'd21, 0);
    issue(1'b1, 32'h4, 32'h0811_2023, 0);
    issue(1'b1, 32'h8, 32'h91A0_E9A8, 0);
    issue(1'b1, 32'hC, 32'h80E0_E2F1, 0);
  endtask

  task automatic test_reads();
    issue(1'b0, 32'h0, 32'h1234_5678, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (slave_mem[i] !== exp_mem[i]) begin
        bad++;
        $display("[TB] FAIL slave_reg%0d got=%h exp=%h", i, slave_mem[i], exp_mem[i]);
      end
    end
    issue(1'b0, 32'h4, 32'h0, 0);
    issue(1'b0, 32'h8, 32'h0, 0);
    issue(1'b0, 32'hC, 32'h0, 0);
  endtask

  task automatic test_wait_states();
    issue(1'b0, 32'h8, 32'hA5A5_A5A5, 3);
    issue(1'b1, 32'h4, 32'h5A5A_0001, 2);
    issue(1'b0, 32'h4, 32'h0, 1);
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    issue(1'b0, 32'h8, 32'h0, 15);
    PWRITE_MASTER = 1'b0; PADDR_MASTER = 32'h0; PWDATA_MASTER = 32'h77;
    PREADY = 1'b0;
    step();
    exp_prdata = 32'hDEAD_BEEF;
    pend_valid = 1'b1; pend_we = 1'b0; pend_addr = 32'h0; pend_data = 32'h77;
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA_MASTER} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 32'h77, 32'hDEAD_BEEF}) begin
      bad++;
      $display("[TB] FAIL timeout_abort got=%h exp=%h",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA_MASTER},
               {1'b1, 1'b0, 1'b0, 32'h0, 32'h77, 32'hDEAD_BEEF});
    end
    PREADY = 1'b1;
    step();
    total++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL timeout_access got=%b exp=11", {PSEL, PENABLE});
    end
  endtask
`else
  task automatic test_long_wait();
    issue(1'b0, 32'hC, 32'h0, 20);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom), {28'h0, 2'($urandom), 2'b00}, $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 32'h8, 32'h0, 2);
    PRESET = 1'b1; PREADY = 1'b1;
    step();
    model_reset();
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA_MASTER} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mid_access got=%h exp=0",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA_MASTER});
    end
    PRESET = 1'b0;
    issue(1'b1, 32'h4, 32'hCAFE_0004, 0);
    issue(1'b0, 32'h4, 32'h0, 0);
    issue(1'b0, 32'h0, 32'h0, 1);
    issue(1'b1, 32'h8, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_writes();
    test_reads();
    test_wait_states();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
